score_bcd_formatter: RTL and testbench



---
 rtl/go_pkg.sv | 18 +
 rtl/bin2bcd_step.sv | 34 +++
 rtl/score_bcd_formatter.sv | 121 ++++++++++++
 tb/tb_score_bcd_formatter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/go_pkg.sv
// Shared definitions for the score display path: formatter FSM states and
// the default tag nibbles shown in front of each score.
package go_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } fmt_state_t;

   // 4'hB renders as "b" (black) on digit 7; 4'hC marks white on digit 3.
   localparam logic [3:0] DEF_BLACK_TAG = 4'hB;
   localparam logic [3:0] DEF_WHITE_TAG = 4'hC;

   // Three BCD digits cover any 8-bit count.
   localparam int unsigned BCD_W = 12;

endpackage : go_pkg

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration for a single channel: every BCD nibble >= 5
// gets +3, then {bcd, bin} is shifted left by one. Purely combinational.
// Ports:
//   bcd      current 12-bit BCD accumulator
//   bin      current binary shift register
//   bcd_next accumulator after add-3 and shift
//   bin_next binary register after shift
module bin2bcd_step
   import go_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic [BCD_W-1:0] bcd,
   input  logic [CNT_W-1:0] bin,
   output logic [BCD_W-1:0] bcd_next,
   output logic [CNT_W-1:0] bin_next
);

   logic [BCD_W-1:0] adj;

   // Add-3 correction per nibble so the following shift carries correctly.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   assign bcd_next = {adj[BCD_W-2:0], bin[CNT_W-1]};
   assign bin_next = {bin[CNT_W-2:0], 1'b0};

endmodule : bin2bcd_step

// File: rtl/score_bcd_formatter.sv
// Converts black/white territory counts to 3-digit BCD with an iterative
// double-dabble and packs them with tag nibbles for the 8-digit hex display.
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-high reset
//   bcount_in     black territory count
//   wcount_in     white territory count
//   update_in     one-cycle conversion request
//   seg_data_out  {BLACK_TAG, B bcd[11:0], WHITE_TAG, W bcd[11:0]}
//   busy_out      high while a conversion is in progress
//   done_out      one-cycle pulse when seg_data_out has just been updated
module score_bcd_formatter
   import go_pkg::*;
#(
   parameter logic [3:0]  BLACK_TAG = DEF_BLACK_TAG,
   parameter logic [3:0]  WHITE_TAG = DEF_WHITE_TAG,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [CNT_W-1:0] bcount_in,
   input  logic [CNT_W-1:0] wcount_in,
   input  logic             update_in,
   output logic [31:0]      seg_data_out,
   output logic             busy_out,
   output logic             done_out
);

   localparam int unsigned CTR_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam logic [CTR_W-1:0] LAST_ITER = CTR_W'(CNT_W - 1);
   localparam logic [31:0] SEG_RESET = {BLACK_TAG, 12'h000, WHITE_TAG, 12'h000};

   fmt_state_t       state;
   logic             pending;
   logic [CTR_W-1:0] iter;
   logic [CNT_W-1:0] bin_b, bin_w;
   logic [BCD_W-1:0] bcd_b, bcd_w;
   logic [CNT_W-1:0] bin_b_nx, bin_w_nx;
   logic [BCD_W-1:0] bcd_b_nx, bcd_w_nx;

   bin2bcd_step #(.CNT_W(CNT_W)) u_step_b (
      .bcd      (bcd_b),
      .bin      (bin_b),
      .bcd_next (bcd_b_nx),
      .bin_next (bin_b_nx)
   );

   bin2bcd_step #(.CNT_W(CNT_W)) u_step_w (
      .bcd      (bcd_w),
      .bin      (bin_w),
      .bcd_next (bcd_w_nx),
      .bin_next (bin_w_nx)
   );

   // Conversion FSM, datapath registers and registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state        <= IDLE;
         pending      <= 1'b0;
         iter         <= '0;
         bin_b        <= '0;
         bin_w        <= '0;
         bcd_b        <= '0;
         bcd_w        <= '0;
         seg_data_out <= SEG_RESET;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (update_in) begin
                  bin_b    <= bcount_in;
                  bin_w    <= wcount_in;
                  bcd_b    <= '0;
                  bcd_w    <= '0;
                  iter     <= '0;
                  busy_out <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               bin_b <= bin_b_nx;
               bin_w <= bin_w_nx;
               bcd_b <= bcd_b_nx;
               bcd_w <= bcd_w_nx;
               iter  <= iter + CTR_W'(1);
               // Requests during a conversion collapse into one rerun.
               if (update_in) begin
                  pending <= 1'b1;
               end
               if (iter == LAST_ITER) begin
                  state <= DONE;
               end
            end
            DONE: begin
               seg_data_out <= {BLACK_TAG, bcd_b, WHITE_TAG, bcd_w};
               done_out     <= 1'b1;
               if (pending || update_in) begin
                  // Rerun uses the inputs present now, not at request time.
                  bin_b   <= bcount_in;
                  bin_w   <= wcount_in;
                  bcd_b   <= '0;
                  bcd_w   <= '0;
                  iter    <= '0;
                  pending <= 1'b0;
                  state   <= SHIFT;
               end else begin
                  busy_out <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule : score_bcd_formatter

// File: tb/tb_score_bcd_formatter.sv
// Self-checking bench for score_bcd_formatter: directed scenarios plus
// randomized counts against a decimal-arithmetic reference.
module tb_score_bcd_formatter;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [7:0]  bcount_in;
   logic [7:0]  wcount_in;
   logic        update_in;
   logic [31:0] seg_data_out;
   logic        busy_out;
   logic        done_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [31:0] exp_seg;

   score_bcd_formatter dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .bcount_in    (bcount_in),
      .wcount_in    (wcount_in),
      .update_in    (update_in),
      .seg_data_out (seg_data_out),
      .busy_out     (busy_out),
      .done_out     (done_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: decimal digits from plain division.
   function automatic logic [31:0] ref_seg(input int b, input int w);
      logic [11:0] db, dw;
      db = 12'(((b / 100) << 8) | (((b / 10) % 10) << 4) | (b % 10));
      dw = 12'(((w / 100) << 8) | (((w / 10) % 10) << 4) | (w % 10));
      return {4'hB, db, 4'hC, dw};
   endfunction

   // Advance past the next rising edge; sample 1 time unit later.
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   // Present counts and pulse update on the next edge (edge k).
   task automatic start(input int b, input int w);
      bcount_in = 8'(b);
      wcount_in = 8'(w);
      update_in = 1'b1;
      tick();
      update_in = 1'b0;
   endtask

   // Full isolated conversion with per-cycle latency checks.
   task automatic convert(input int b, input int w);
      start(b, w);
      check("busy_after_k", 32'(busy_out), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("busy_mid", 32'(busy_out), 32'd1);
         check("done_mid", 32'(done_out), 32'd0);
         check("seg_hold", seg_data_out, exp_seg);
      end
      tick();
      exp_seg = ref_seg(b, w);
      check("done_k9", 32'(done_out), 32'd1);
      check("seg_k9", seg_data_out, exp_seg);
      check("busy_k9", 32'(busy_out), 32'd0);
      tick();
      check("done_pulse_len", 32'(done_out), 32'd0);
   endtask

   // Tick until done_out or budget expires; returns cycles consumed.
   task automatic wait_done(input int budget, output int used);
      used = 0;
      while (done_out !== 1'b1 && used < budget) begin
         tick();
         used++;
      end
      if (done_out !== 1'b1) check("done_timeout", 32'(done_out), 32'd1);
   endtask

   initial begin
      int k, used, pulses, pos, b1, w1, b2, w2;
      rst_in    = 1'b1;
      bcount_in = '0;
      wcount_in = '0;
      update_in = 1'b0;
      exp_seg   = 32'hB000_C000;
      repeat (3) tick();
      rst_in = 1'b0;

      // Reset state and idle behaviour
      check("rst_seg", seg_data_out, 32'hB000_C000);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_done", 32'(done_out), 32'd0);
      pulses = 0;
      bcount_in = 8'd77;
      wcount_in = 8'd66;
      repeat (20) begin
         tick();
         if (done_out) pulses++;
      end
      check("idle_no_done", 32'(pulses), 32'd0);
      check("idle_seg", seg_data_out, 32'hB000_C000);

      // Directed single conversions
      convert(81, 0);
      check("seg_81_0", seg_data_out, 32'hB081_C000);
      convert(255, 200);
      check("seg_255_200", seg_data_out, 32'hB255_C200);
      convert(45, 36);
      convert(9, 10);
      check("seg_9_10", seg_data_out, 32'hB009_C010);
      convert(0, 255);

      // Requests during SHIFT collapse into one pending rerun
      start(12, 34);
      k = cyc;
      repeat (2) tick();
      bcount_in = 8'd56;
      wcount_in = 8'd78;
      update_in = 1'b1;
      tick();
      update_in = 1'b0;
      tick();
      update_in = 1'b1;
      tick();
      update_in = 1'b0;
      wait_done(30, used);
      check("pend_first_lat", 32'(cyc - k), 32'd9);
      check("pend_first_seg", seg_data_out, 32'hB012_C034);
      check("pend_busy_kept", 32'(busy_out), 32'd1);
      pulses = 1;
      tick();
      wait_done(30, used);
      if (done_out) pulses++;
      check("pend_second_lat", 32'(cyc - k), 32'd18);
      check("pend_second_seg", seg_data_out, 32'hB056_C078);
      repeat (12) begin
         tick();
         if (done_out) pulses++;
      end
      check("pend_two_pulses", 32'(pulses), 32'd2);
      check("pend_idle_busy", 32'(busy_out), 32'd0);

      // Update on the DONE edge restarts with no IDLE cycle
      start(1, 2);
      k = cyc;
      repeat (8) tick();
      bcount_in = 8'd7;
      wcount_in = 8'd8;
      update_in = 1'b1;
      tick();
      update_in = 1'b0;
      check("b2b_done", 32'(done_out), 32'd1);
      check("b2b_first_seg", seg_data_out, 32'hB001_C002);
      check("b2b_busy", 32'(busy_out), 32'd1);
      tick();
      wait_done(30, used);
      check("b2b_lat", 32'(cyc - k), 32'd18);
      check("b2b_seg", seg_data_out, 32'hB007_C008);
      tick();

      // Asynchronous reset mid-conversion
      exp_seg = 32'hB007_C008;
      convert(99, 99);
      check("seg_99_99", seg_data_out, 32'hB099_C099);
      start(50, 60);
      repeat (3) tick();
      #2;
      rst_in = 1'b1;
      #1;
      check("arst_seg", seg_data_out, 32'hB000_C000);
      check("arst_busy", 32'(busy_out), 32'd0);
      check("arst_done", 32'(done_out), 32'd0);
      repeat (2) tick();
      #2;
      rst_in = 1'b0;
      pulses = 0;
      repeat (15) begin
         tick();
         if (done_out) pulses++;
      end
      check("arst_no_done", 32'(pulses), 32'd0);
      check("arst_seg_after", seg_data_out, 32'hB000_C000);
      exp_seg = 32'hB000_C000;
      convert(123, 4);

      // Randomized isolated conversions
      for (int i = 0; i < 20; i++) begin
         convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end

      // Randomized pending reruns with a request at a random SHIFT edge
      for (int i = 0; i < 8; i++) begin
         b1 = int'($urandom_range(0, 255));
         w1 = int'($urandom_range(0, 255));
         b2 = int'($urandom_range(0, 255));
         w2 = int'($urandom_range(0, 255));
         pos = int'($urandom_range(1, 8));
         start(b1, w1);
         k = cyc;
         repeat (pos - 1) tick();
         bcount_in = 8'(b2);
         wcount_in = 8'(w2);
         update_in = 1'b1;
         tick();
         update_in = 1'b0;
         wait_done(30, used);
         check("rnd_first_lat", 32'(cyc - k), 32'd9);
         check("rnd_first_seg", seg_data_out, ref_seg(b1, w1));
         tick();
         wait_done(30, used);
         check("rnd_second_lat", 32'(cyc - k), 32'd18);
         check("rnd_second_seg", seg_data_out, ref_seg(b2, w2));
         tick();
         check("rnd_idle_busy", 32'(busy_out), 32'd0);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule : tb_score_bcd_formatter
